// File: rtl/control_unit.sv
// Mini-SRC hardwired control sequencer: fetch F0-F2, then per-class execute steps E3-E7.
// Strobes are registered from the next state, so each one is a flop output aligned with its state.
module control_unit #(
    parameter int OPW             = 5,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        run,
    output logic        PCout, PCin, IncPC,
    output logic        MARin, MDRin, MDRout, Read, Write,
    output logic        IRin, Yin, ZLowIn, ZHighIn,
    output logic        ZLowOut, ZHighout, HIout, LOout, HIin, LOin,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, RCout,
    output logic        CONin, InPortOut, OutPortIn
);

    typedef enum logic [3:0] {
        S_RST, S_F0, S_F1, S_F2, S_E3, S_E4, S_E5, S_E6, S_E7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ALUR, C_NEGNOT, C_ALUI, C_MULDIV, C_LD, C_ST, C_BR,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
    } cls_t;

    typedef struct packed {
        logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, rd, wr;
        logic ir_in, y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_out, lo_out;
        logic hi_in, lo_in, gra, grb, grc, r_in, r_out, ba_out, rc_out;
        logic con_in, inport_out, outport_in;
    } strobe_t;

    function automatic cls_t classify(input logic [OPW-1:0] op);
        cls_t c;
        case (op)
            5'd0:                                  c = C_LD;
            5'd1, 5'd11, 5'd12, 5'd13:             c = C_ALUI;
            5'd2:                                  c = C_ST;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
            5'd9, 5'd10:                           c = C_ALUR;
            5'd14, 5'd15:                          c = C_MULDIV;
            5'd16, 5'd17:                          c = C_NEGNOT;
            5'd18:                                 c = C_BR;
            5'd19:                                 c = C_JR;
            5'd21:                                 c = C_IN;
            5'd22:                                 c = C_OUT;
            5'd23:                                 c = C_MFHI;
            5'd24:                                 c = C_MFLO;
            5'd25:                                 c = C_NOP;
            5'd26:                                 c = C_HALT;
            default: c = (HALT_ON_ILLEGAL != 0) ? C_HALT : C_NOP;
        endcase
        return c;
    endfunction

    // Final execute step of each class; fetch-only classes end in F2
    function automatic state_t last_step(input cls_t c);
        case (c)
            C_ALUR, C_ALUI:                     return S_E5;
            C_NEGNOT:                           return S_E4;
            C_MULDIV, C_BR:                     return S_E6;
            C_LD, C_ST:                         return S_E7;
            C_JR, C_IN, C_OUT, C_MFHI, C_MFLO:  return S_E3;
            default:                            return S_F2;
        endcase
    endfunction

    function automatic strobe_t decode(input state_t st, input cls_t c, input logic cf);
        strobe_t s;
        s = '0;
        case (st)
            S_F0: begin s.pc_out = 1'b1; s.mar_in = 1'b1; end
            S_F1: begin s.rd = 1'b1; s.mdr_in = 1'b1; s.inc_pc = 1'b1; s.pc_in = 1'b1; end
            S_F2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
            S_E3: case (c)
                C_ALUR:              begin s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
                C_NEGNOT:            begin s.grb = 1'b1; s.r_out = 1'b1; s.zlow_in = 1'b1; end
                C_ALUI, C_LD, C_ST:  begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
                C_MULDIV:            begin s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
                C_BR:                begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
                C_JR:                begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
                C_IN:                begin s.inport_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
                C_OUT:               begin s.gra = 1'b1; s.r_out = 1'b1; s.outport_in = 1'b1; end
                C_MFHI:              begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
                C_MFLO:              begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
                default:             s = '0;
            endcase
            S_E4: case (c)
                C_ALUR:              begin s.grc = 1'b1; s.r_out = 1'b1; s.zlow_in = 1'b1; end
                C_NEGNOT:            begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
                C_ALUI, C_LD, C_ST:  begin s.rc_out = 1'b1; s.zlow_in = 1'b1; end
                C_MULDIV:            begin s.grb = 1'b1; s.r_out = 1'b1; s.zlow_in = 1'b1; s.zhigh_in = 1'b1; end
                C_BR:                begin s.pc_out = 1'b1; s.y_in = 1'b1; end
                default:             s = '0;
            endcase
            S_E5: case (c)
                C_ALUR, C_ALUI:      begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
                C_LD, C_ST:          begin s.zlow_out = 1'b1; s.mar_in = 1'b1; end
                C_MULDIV:            begin s.zlow_out = 1'b1; s.lo_in = 1'b1; end
                C_BR:                begin s.rc_out = 1'b1; s.zlow_in = 1'b1; end
                default:             s = '0;
            endcase
            S_E6: case (c)
                C_MULDIV:            begin s.zhigh_out = 1'b1; s.hi_in = 1'b1; end
                C_LD:                begin s.rd = 1'b1; s.mdr_in = 1'b1; end
                C_ST:                begin s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1; end
                C_BR:                begin s.zlow_out = 1'b1; s.pc_in = cf; end
                default:             s = '0;
            endcase
            S_E7: case (c)
                C_LD:                begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
                C_ST:                s.wr = 1'b1;
                default:             s = '0;
            endcase
            default: s = '0;
        endcase
        return s;
    endfunction

    state_t  state_r, next_s, done_s;
    cls_t    cls_r, cls_next_s, op_cls_s;
    logic    stop_pend_r, pend_keep_s, pend_next_s, stop_req_s;
    strobe_t strobe_r;
    logic    run_r;
    logic    unused_ir_s;

    assign unused_ir_s = ^ir[31-OPW:0];

    // Next state, latched class and stop request held from fetch to the final step
    always_comb begin
        next_s      = S_RST;
        cls_next_s  = cls_r;
        pend_keep_s = stop_pend_r;
        op_cls_s    = classify(ir[31:32-OPW]);
        stop_req_s  = stop_pend_r | stop;
        done_s      = stop_req_s ? S_HALT : S_F0;
        case (state_r)
            S_RST: next_s = S_F0;
            S_F0, S_F1: begin
                next_s      = (state_r == S_F0) ? S_F1 : S_F2;
                pend_keep_s = stop_req_s;
            end
            S_F2: begin
                cls_next_s  = op_cls_s;
                pend_keep_s = stop_req_s;
                if (op_cls_s == C_HALT) begin
                    next_s = S_HALT;
                end else if (op_cls_s == C_NOP) begin
                    next_s = done_s;
                end else begin
                    next_s = S_E3;
                end
            end
            S_E3, S_E4, S_E5, S_E6, S_E7: begin
                if (state_r == last_step(cls_r) || state_r == S_E7) begin
                    next_s = done_s;
                end else begin
                    next_s = state_t'(state_r + 4'd1);
                end
            end
            S_HALT: next_s = S_HALT;
            default: next_s = S_RST;
        endcase
        pend_next_s = (next_s == S_F0 || next_s == S_HALT) ? 1'b0 : pend_keep_s;
    end

    // State, class and registered strobe outputs
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r     <= S_RST;
            cls_r       <= C_NOP;
            stop_pend_r <= 1'b0;
            strobe_r    <= '0;
            run_r       <= 1'b0;
        end else begin
            state_r     <= next_s;
            cls_r       <= cls_next_s;
            stop_pend_r <= pend_next_s;
            strobe_r    <= decode(next_s, cls_next_s, con_ff);
            run_r       <= (next_s != S_RST) && (next_s != S_HALT);
        end
    end

    assign run       = run_r;
    assign PCout     = strobe_r.pc_out;
    assign PCin      = strobe_r.pc_in;
    assign IncPC     = strobe_r.inc_pc;
    assign MARin     = strobe_r.mar_in;
    assign MDRin     = strobe_r.mdr_in;
    assign MDRout    = strobe_r.mdr_out;
    assign Read      = strobe_r.rd;
    assign Write     = strobe_r.wr;
    assign IRin      = strobe_r.ir_in;
    assign Yin       = strobe_r.y_in;
    assign ZLowIn    = strobe_r.zlow_in;
    assign ZHighIn   = strobe_r.zhigh_in;
    assign ZLowOut   = strobe_r.zlow_out;
    assign ZHighout  = strobe_r.zhigh_out;
    assign HIout     = strobe_r.hi_out;
    assign LOout     = strobe_r.lo_out;
    assign HIin      = strobe_r.hi_in;
    assign LOin      = strobe_r.lo_in;
    assign Gra       = strobe_r.gra;
    assign Grb       = strobe_r.grb;
    assign Grc       = strobe_r.grc;
    assign Rin       = strobe_r.r_in;
    assign Rout      = strobe_r.r_out;
    assign BAout     = strobe_r.ba_out;
    assign RCout     = strobe_r.rc_out;
    assign CONin     = strobe_r.con_in;
    assign InPortOut = strobe_r.inport_out;
    assign OutPortIn = strobe_r.outport_in;

endmodule
